// File: rtl/window_addr_pkg.sv
// -----------------------------------------------------------------------------
// window_addr_pkg
// Shared types and elaboration-time helpers for the sliding-window address
// generator: the controller state encoding and the constant functions that
// derive output-map geometry and per-lane address offsets from the
// image/kernel parameters.
// -----------------------------------------------------------------------------
package window_addr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Number of window positions along x.
    function automatic int calc_out_w(input int img_w, input int k, input int stride);
        return (img_w - k) / stride + 1;
    endfunction

    // Number of window positions along y.
    function automatic int calc_out_h(input int img_h, input int k, input int stride);
        return (img_h - k) / stride + 1;
    endfunction

    // Address distance between the first windows of neighbouring lanes.
    function automatic int calc_lane_ofs(input int img_w, input int img_h, input int k,
                                         input int stride, input int lanes);
        return (calc_out_h(img_h, k, stride) / lanes) * stride * img_w;
    endfunction

    // Counter width able to hold 0..mod-1 (at least one bit).
    function automatic int cnt_w(input int mod);
        return (mod > 1) ? $clog2(mod) : 1;
    endfunction

endpackage

// File: rtl/window_addr_gen_if.sv
// -----------------------------------------------------------------------------
// window_addr_gen_if
// Bundles the controller handshake (start/base_addr/busy/done) and the
// address stream toward the datapath (addr/addr_valid/addr_ready plus the
// window framing flags).
//   master : the address generator (drives addr_valid, addr, win_first,
//            win_last, busy, done; receives start, base_addr, addr_ready)
//   slave  : controller plus consumer side, mirror directions
// -----------------------------------------------------------------------------
interface window_addr_gen_if #(
    parameter int LANES  = 2,
    parameter int ADDR_W = 8
);
    logic                             start;
    logic [ADDR_W-1:0]                base_addr;
    logic                             addr_ready;
    logic                             addr_valid;
    logic [LANES-1:0][ADDR_W-1:0]     addr;
    logic                             win_first;
    logic                             win_last;
    logic                             busy;
    logic                             done;

    modport master (
        input  start, base_addr, addr_ready,
        output addr_valid, addr, win_first, win_last, busy, done
    );

    modport slave (
        output start, base_addr, addr_ready,
        input  addr_valid, addr, win_first, win_last, busy, done
    );
endinterface

// File: rtl/wrap_counter.sv
// -----------------------------------------------------------------------------
// wrap_counter
// Modulus-MOD up counter with synchronous clear and count enable. o_tc is
// high while the count sits at MOD-1, so chained counters advance on
// (enable && every lower terminal count).
//   clk, reset : clock, asynchronous active-high reset
//   i_clr      : synchronous clear (wins over i_en)
//   i_en       : advance by one, wrapping to 0 after MOD-1
//   o_cnt      : current count
//   o_tc       : terminal count (o_cnt == MOD-1)
// -----------------------------------------------------------------------------
module wrap_counter #(
    parameter int MOD = 4,
    parameter int W   = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_cnt,
    output logic         o_tc
);
    logic [W-1:0] r_cnt;

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == W'(MOD - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_tc ? '0 : r_cnt + W'(1);
        end
    end
endmodule

// File: rtl/window_addr_gen.sv
// -----------------------------------------------------------------------------
// window_addr_gen
// Walks a KxK kernel over an IMG_W x IMG_H image at STRIDE and emits one read
// address per tap on LANES ports; each lane owns an equal band of output rows.
// Order (innermost first): kc, kr, ox, oy.
//   clk, reset     : clock, asynchronous active-high reset
//   bus.start      : run request, honoured only in IDLE or DONE
//   bus.base_addr  : image base, captured when start is honoured
//   bus.addr_ready : consumer takes the current address set
//   bus.addr_valid : bus.addr holds a tap
//   bus.addr       : per-lane tap address (modulo 2^ADDR_W)
//   bus.win_first  : tap is kr=0,kc=0 of its window
//   bus.win_last   : tap is kr=K-1,kc=K-1 of its window
//   bus.busy       : WAIT or RUN
//   bus.done       : DONE
// -----------------------------------------------------------------------------
module window_addr_gen
    import window_addr_pkg::*;
#(
    parameter int IMG_W       = 12,
    parameter int IMG_H       = 12,
    parameter int K           = 5,
    parameter int STRIDE      = 1,
    parameter int LANES       = 2,
    parameter int ADDR_W      = 8,
    parameter int START_DELAY = 0
) (
    input  logic               clk,
    input  logic               reset,
    window_addr_gen_if.master  bus
);
    localparam int OUT_W         = calc_out_w(IMG_W, K, STRIDE);
    localparam int OUT_H         = calc_out_h(IMG_H, K, STRIDE);
    localparam int ROWS_PER_LANE = OUT_H / LANES;
    localparam int LANE_OFS      = calc_lane_ofs(IMG_W, IMG_H, K, STRIDE, LANES);
    localparam int KW            = cnt_w(K);
    localparam int OXW           = cnt_w(OUT_W);
    localparam int OYW           = cnt_w(ROWS_PER_LANE);
    localparam int DLY_W         = cnt_w(START_DELAY);
    localparam int DLY_LAST      = (START_DELAY > 0) ? START_DELAY - 1 : 0;

    // Step sizes of the running bases; constants, so no datapath multiplier.
    localparam logic [ADDR_W-1:0] C_ROW  = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] C_COL  = ADDR_W'(STRIDE);
    localparam logic [ADDR_W-1:0] C_BAND = ADDR_W'(STRIDE * IMG_W);

    if (K > IMG_W) begin : g_bad_k_w
        $error("window_addr_gen: K=%0d exceeds IMG_W=%0d", K, IMG_W);
    end
    if (K > IMG_H) begin : g_bad_k_h
        $error("window_addr_gen: K=%0d exceeds IMG_H=%0d", K, IMG_H);
    end
    if ((OUT_H % LANES) != 0) begin : g_bad_lanes
        $error("window_addr_gen: OUT_H=%0d not divisible by LANES=%0d", OUT_H, LANES);
    end

    state_t                        r_state;
    logic                          r_valid;
    logic [DLY_W-1:0]              r_dly;
    logic [LANES-1:0][ADDR_W-1:0]  r_addr;
    logic [LANES-1:0][ADDR_W-1:0]  w_lane_ofs;

    // Running bases for lane 0: r_org = current output-row band origin,
    // r_win = current window origin, r_row = current kernel row start.
    logic [ADDR_W-1:0] r_org, r_win, r_row;
    logic [ADDR_W-1:0] w_nxt_org, w_nxt_win, w_nxt_row, w_nxt_tap;

    logic           w_start_acc, w_fire, w_final;
    logic           w_kc_tc, w_kr_tc, w_ox_tc, w_oy_tc;
    logic [KW-1:0]  w_kc, w_kr;
    logic [OXW-1:0] w_ox;
    logic [OYW-1:0] w_oy;
    logic           w_unused_cnt;

    assign w_start_acc  = bus.start && ((r_state == IDLE) || (r_state == DONE));
    assign w_fire       = r_valid && bus.addr_ready;
    assign w_final      = w_fire && w_kc_tc && w_kr_tc && w_ox_tc && w_oy_tc;
    assign w_unused_cnt = ^{w_ox, w_oy};

    for (genvar g = 0; g < LANES; g++) begin : g_lane_ofs
        assign w_lane_ofs[g] = ADDR_W'(g * LANE_OFS);
    end

    wrap_counter #(.MOD(K), .W(KW)) u_kc (
        .clk(clk), .reset(reset), .i_clr(w_start_acc), .i_en(w_fire),
        .o_cnt(w_kc), .o_tc(w_kc_tc)
    );
    wrap_counter #(.MOD(K), .W(KW)) u_kr (
        .clk(clk), .reset(reset), .i_clr(w_start_acc), .i_en(w_fire && w_kc_tc),
        .o_cnt(w_kr), .o_tc(w_kr_tc)
    );
    wrap_counter #(.MOD(OUT_W), .W(OXW)) u_ox (
        .clk(clk), .reset(reset), .i_clr(w_start_acc),
        .i_en(w_fire && w_kc_tc && w_kr_tc),
        .o_cnt(w_ox), .o_tc(w_ox_tc)
    );
    wrap_counter #(.MOD(ROWS_PER_LANE), .W(OYW)) u_oy (
        .clk(clk), .reset(reset), .i_clr(w_start_acc),
        .i_en(w_fire && w_kc_tc && w_kr_tc && w_ox_tc),
        .o_cnt(w_oy), .o_tc(w_oy_tc)
    );

    // Next lane-0 tap: the carry out of each counter selects which running
    // base advances; lower bases reload from the one that moved.
    always_comb begin
        w_nxt_org = r_org;
        w_nxt_win = r_win;
        w_nxt_row = r_row;
        w_nxt_tap = r_addr[0] + ADDR_W'(1);
        if (w_kc_tc) begin
            if (!w_kr_tc) begin
                w_nxt_row = r_row + C_ROW;
            end else if (!w_ox_tc) begin
                w_nxt_win = r_win + C_COL;
                w_nxt_row = w_nxt_win;
            end else begin
                w_nxt_org = r_org + C_BAND;
                w_nxt_win = w_nxt_org;
                w_nxt_row = w_nxt_org;
            end
            w_nxt_tap = w_nxt_row;
        end
    end

    // Base registers only matter while RUN, so they carry no reset.
    always_ff @(posedge clk) begin
        if (w_start_acc) begin
            r_org <= bus.base_addr;
            r_win <= bus.base_addr;
            r_row <= bus.base_addr;
        end else if (w_fire) begin
            r_org <= w_nxt_org;
            r_win <= w_nxt_win;
            r_row <= w_nxt_row;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_dly   <= '0;
            r_addr  <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_start_acc) begin
                        r_dly <= '0;
                        for (int l = 0; l < LANES; l++) begin
                            r_addr[l] <= bus.base_addr + w_lane_ofs[l];
                        end
                        if (START_DELAY == 0) begin
                            r_state <= RUN;
                            r_valid <= 1'b1;
                        end else begin
                            r_state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (r_dly == DLY_W'(DLY_LAST)) begin
                        r_state <= RUN;
                        r_valid <= 1'b1;
                    end else begin
                        r_dly <= r_dly + DLY_W'(1);
                    end
                end
                RUN: begin
                    if (w_final) begin
                        r_state <= DONE;
                        r_valid <= 1'b0;
                    end else if (w_fire) begin
                        for (int l = 0; l < LANES; l++) begin
                            r_addr[l] <= w_nxt_tap + w_lane_ofs[l];
                        end
                    end
                end
            endcase
        end
    end

    // Framing flags are qualified by valid so they read 0 outside RUN.
    assign bus.addr_valid = r_valid;
    assign bus.addr       = r_addr;
    assign bus.win_first  = r_valid && (w_kc == '0) && (w_kr == '0);
    assign bus.win_last   = r_valid && w_kc_tc && w_kr_tc;
    assign bus.busy       = (r_state == WAIT) || (r_state == RUN);
    assign bus.done       = (r_state == DONE);

endmodule

// File: doc/window_addr_gen.md
# window_addr_gen

Parametrised sliding-window address generator for the conv/pool feature-map memories. It walks a K×K kernel over an IMG_W×IMG_H image at a configurable stride and emits one read address per tap on LANES parallel ports. Each lane covers an equal band of output rows. The block sits between the layer controller (start/done) and the layer's input-memory read ports, with a valid/ready handshake toward the datapath.

## Interface
Parameters:
- IMG_W, 12: input image width in pixels
- IMG_H, 12: input image height in pixels
- K, 5: kernel side length
- STRIDE, 1: window step in pixels, applied in both x and y
- LANES, 2: parallel address ports. OUT_H must be divisible by LANES.
- ADDR_W, 8: address width
- START_DELAY, 0: idle cycles between start acceptance and the first valid address

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request. Accepted only in IDLE or DONE.
- base_addr  in  ADDR_W  image base address, sampled on the cycle start is accepted
- addr_ready  in  1  consumer accepts the current address set
- addr_valid  out  1  addr holds a valid tap
- addr  out  LANES×ADDR_W  per-lane tap address
- win_first  out  1  current tap is kr=0, kc=0 of a window
- win_last  out  1  current tap is kr=K-1, kc=K-1 of a window
- busy  out  1  high in WAIT or RUN
- done  out  1  high in DONE

## Operation
Derived constants:
- OUT_W = (IMG_W-K)/STRIDE+1 and OUT_H = (IMG_H-K)/STRIDE+1, using integer division.
- ROWS_PER_LANE = OUT_H/LANES.
- LANE_OFS = ROWS_PER_LANE·STRIDE·IMG_W.

Iteration order, innermost first:
- kc: 0..K-1
- kr: 0..K-1
- ox: 0..OUT_W-1
- oy: 0..ROWS_PER_LANE-1

Address rules:
- addr[l] = base + (oy·STRIDE+kr)·IMG_W + ox·STRIDE + kc + l·LANE_OFS.
- All arithmetic is modulo 2^ADDR_W; wrap-around is legal and must not be flagged.
- Addresses are generated incrementally with adders and running row/column bases. No multipliers in the datapath.

Transfer count:
- Total transfers per run = OUT_W·ROWS_PER_LANE·K·K.

FSM:
- IDLE → WAIT when start is accepted. Transition is to RUN instead if START_DELAY=0.
- WAIT → RUN after START_DELAY cycles.
- RUN → DONE on the handshake of the final tap.
- DONE → WAIT/RUN on start. Otherwise DONE holds.

Rules:
- A transfer occurs when addr_valid && addr_ready.
- When addr_ready=0, addr, win_first and win_last hold stable.
- start in WAIT or RUN is ignored. base_addr is not re-sampled.
- Reset in any state returns to IDLE at once. All counters are cleared.

## Timing
Reset values:
- All outputs 0.
- addr all 0.
- FSM in IDLE.

Latency:
- With start accepted at cycle t, addr_valid=1 from cycle t+1+START_DELAY with the first tap presented.
- Throughput is one tap per cycle while addr_ready=1.

Completion:
- On the cycle after the final transfer: addr_valid=0, busy=0, done=1.
- done stays high until start or reset. It drops the cycle after start is accepted.

## Structure
- Package window_addr_pkg holds:
  - the state enum (IDLE, WAIT, RUN, DONE);
  - constant functions for OUT_W, OUT_H and LANE_OFS.
- Elaboration-time assertions check K ≤ IMG_W, K ≤ IMG_H and OUT_H % LANES == 0.
- Sub-module wrap_counter is a parametrised modulus counter with enable, clear and a terminal-count output. It is instantiated four times (kc, kr, ox, oy) and chained by terminal count.

## Test plan
- **Defaults, base 0, addr_ready tied high.**
  - First cycle: lane0=0, lane1=48, win_first=1.
  - Taps 1–25 on lane0: 0,1,2,3,4,12,…,52; tap 25 has win_last=1.
  - Tap 26 = 1.
  - Tap 201 = 12.
  - Final tap: lane0=95, lane1=143.
  - 800 transfers total, then done=1 on the next cycle.
- **Random addr_ready backpressure.**
  - addr, win_first and win_last are stable whenever valid && !ready.
  - Address sequence is identical to the first scenario.
  - Still exactly 800 transfers.
- **base_addr=200 with ADDR_W=8.**
  - First lane1 address = 248.
  - Last lane1 address = 343 mod 256 = 87.
  - No stall at wrap.
- **STRIDE=2, K=3, IMG_W=IMG_H=9, LANES=1.**
  - OUT_W = OUT_H = 4.
  - Window 2 starts at 2; window 5 starts at 18.
  - 144 transfers.
- **START_DELAY=3.**
  - addr_valid rises 4 cycles after start.
  - A start pulse mid-RUN is ignored; the count is unchanged.
  - Back-to-back start from DONE restarts cleanly.
- **reset asserted mid-RUN at transfer 300.**
  - Outputs go to 0 immediately.
  - A subsequent start replays from address base.
